// File: rtl/systolic_edge_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_edge_feeder
// Purpose  : Edge feeder for one side (A rows or B columns) of a systolic
//            array. Accepts one k-step beat of LANES operands per cycle and
//            emits each lane skewed by lane+1 cycles as {data, last}.
//            Optional macro FEEDER_BACK2BACK_EN lets a new tile be accepted
//            during the flush of the previous one.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_edge_feeder #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_K      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data_i,
  input  logic                          in_last_i,
  output logic [LANES*DATA_WIDTH-1:0]   lane_data_o,
  output logic [LANES-1:0]              lane_last_o,
  output logic                          busy_o,
  output logic                          err_o,
  output logic [$clog2(MAX_K+1)-1:0]    k_cnt_o
);

  localparam int              KW      = $clog2(MAX_K + 1);
  localparam int              FCW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [KW-1:0]   K_LAST  = KW'(MAX_K - 1);
  localparam logic [FCW-1:0]  FC_INIT = FCW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t          state;
  logic [FCW-1:0]  fc;
  logic [KW-1:0]   k_cnt;
  logic            err;
  logic            ready;
  logic            acc;
  logic            at_max;
  logic            eff_last;

  // The MAX_K-th beat of a tile always closes it, whatever in_last_i says.
  assign at_max   = (k_cnt == K_LAST);
  assign eff_last = in_last_i | at_max;

`ifdef FEEDER_BACK2BACK_EN
  assign ready = rst_ni;
`else
  assign ready = rst_ni & (state != FLUSH);
`endif

  assign acc = in_valid_i & ready;

  // Tile sequencing: beat counting, flush countdown and sticky overflow flag.
  // k_cnt is 0 in IDLE and FLUSH, so one accept rule covers every state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      fc    <= '0;
      k_cnt <= '0;
      err   <= 1'b0;
    end else begin
      if (acc && !in_last_i && at_max) begin
        err <= 1'b1;
      end
      if (acc) begin
        fc <= FC_INIT;
        if (eff_last) begin
          k_cnt <= '0;
          state <= (LANES == 1) ? IDLE : FLUSH;
        end else begin
          k_cnt <= k_cnt + KW'(1);
          state <= STREAM;
        end
      end else if (state == FLUSH) begin
        fc <= fc - FCW'(1);
        if (fc == FCW'(1)) begin
          state <= IDLE;
        end
      end
    end
  end

  // Per-lane skew chains; lane i is i+1 registers deep. Idle cycles inject
  // zero operands, which leave the PE accumulators untouched.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH:0] stg [0:i];

    // Shift every cycle; stage 0 captures the accepted operand or zero.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int s = 0; s <= i; s++) begin
          stg[s] <= '0;
        end
      end else begin
        stg[0] <= acc ? {in_data_i[i*DATA_WIDTH +: DATA_WIDTH], eff_last}
                      : '0;
        for (int s = 1; s <= i; s++) begin
          stg[s] <= stg[s-1];
        end
      end
    end

    assign lane_data_o[i*DATA_WIDTH +: DATA_WIDTH] = stg[i][DATA_WIDTH:1];
    assign lane_last_o[i]                          = stg[i][0];
  end : g_lane

  assign in_ready_o = ready;
  assign busy_o     = (state != IDLE);
  assign err_o      = err;
  assign k_cnt_o    = k_cnt;

endmodule : systolic_edge_feeder
`default_nettype wire
